// File: rtl/alu_seq_pkg.sv
// Shared types for the add/sub/mul/div sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // True when the operation loops over the shared adder for NBITS cycles;
    // a divide by zero short-circuits to a single EXEC cycle.
    function automatic logic needs_iteration(input logic [1:0] op, input logic b_zero);
        logic iter;
        case (op)
            OP_MUL:  iter = 1'b1;
            OP_DIV:  iter = ~b_zero;
            default: iter = 1'b0;
        endcase
        return iter;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared NBITS-wide adder/subtractor; cout is carry-out on add, borrow on sub.
module alu_addsub #(
    parameter int NBITS = 3
) (
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] y,
    input  logic             sub,
    output logic [NBITS-1:0] sum,
    output logic             cout
);

    logic [NBITS:0] wide_s;

    // One extra bit captures the carry (add) or the borrow (sub, x<y).
    always_comb begin
        if (sub) begin
            wide_s = {1'b0, x} - {1'b0, y};
        end else begin
            wide_s = {1'b0, x} + {1'b0, y};
        end
    end

    assign sum  = wide_s[NBITS-1:0];
    assign cout = wide_s[NBITS];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer time-sharing one adder/subtractor between add, sub, mul and div.
// MUL is LSB-first shift-add, DIV is restoring division; both iterate NBITS
// cycles. acc_r/lo_r form the working register pair for both algorithms.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NBITS = 3
) (
    input  logic               clk_2,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*NBITS-1:0] result,
    output logic               ovf,
    output logic               err
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int W2 = 2 * NBITS;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NBITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r;
    op_t              op_r;
    logic [NBITS-1:0] a_r;
    logic [NBITS-1:0] b_r;
    logic [NBITS-1:0] acc_r;
    logic [NBITS-1:0] lo_r;
    logic [CW-1:0]    cnt_r;

    logic [NBITS-1:0] add_x_s;
    logic [NBITS-1:0] add_y_s;
    logic             add_sub_s;
    logic [NBITS-1:0] add_sum_s;
    logic             add_cout_s;

    logic [NBITS:0]   shift_s;
    logic [NBITS:0]   mul_sum_s;
    logic             div_ok_s;
    logic [NBITS-1:0] acc_nxt_s;
    logic [NBITS-1:0] lo_nxt_s;
    logic             div_zero_s;

    // Restoring division shifts the next dividend bit into the partial remainder.
    assign shift_s    = {acc_r, lo_r[NBITS-1]};
    assign div_zero_s = (b_r == '0);

    alu_addsub #(.NBITS(NBITS)) u_addsub (
        .x    (add_x_s),
        .y    (add_y_s),
        .sub  (add_sub_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Operand mux in front of the single shared adder.
    always_comb begin
        add_x_s   = a_r;
        add_y_s   = b_r;
        add_sub_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                add_sub_s = 1'b0;
            end
            OP_SUB: begin
                add_sub_s = 1'b1;
            end
            OP_MUL: begin
                add_x_s = acc_r;
                add_y_s = a_r;
            end
            OP_DIV: begin
                // shift_s[NBITS] set means remainder >= 2^NBITS > b, so the
                // low-bit difference is exact whenever the trial succeeds.
                add_x_s   = shift_s[NBITS-1:0];
                add_y_s   = b_r;
                add_sub_s = 1'b1;
            end
            default: begin
                add_sub_s = 1'b0;
            end
        endcase
    end

    // Next working-register values for one MUL or DIV iteration.
    always_comb begin
        acc_nxt_s = acc_r;
        lo_nxt_s  = lo_r;
        mul_sum_s = {1'b0, acc_r};
        div_ok_s  = 1'b0;
        case (op_r)
            OP_MUL: begin
                if (lo_r[0]) begin
                    mul_sum_s = {add_cout_s, add_sum_s};
                end else begin
                    mul_sum_s = {1'b0, acc_r};
                end
                {acc_nxt_s, lo_nxt_s} = W2'({mul_sum_s, lo_r} >> 1);
            end
            OP_DIV: begin
                div_ok_s = shift_s[NBITS] | ~add_cout_s;
                if (div_ok_s) begin
                    acc_nxt_s = add_sum_s;
                end else begin
                    acc_nxt_s = shift_s[NBITS-1:0];
                end
                lo_nxt_s = NBITS'({lo_r, div_ok_s});
            end
            default: begin
                acc_nxt_s = acc_r;
                lo_nxt_s  = lo_r;
            end
        endcase
    end

    // Control FSM with registered handshake, result and flags.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            op_r    <= OP_ADD;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            lo_r    <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        op_r  <= op_t'(op);
                        a_r   <= a;
                        b_r   <= b;
                        acc_r <= '0;
                        lo_r  <= (op == OP_MUL) ? b : a;
                        cnt_r <= needs_iteration(op, (b == '0)) ? CNT_LOAD : '0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_r)
                        OP_ADD, OP_SUB: begin
                            result <= {{NBITS{1'b0}}, add_sum_s};
                            ovf    <= add_cout_s;
                        end
                        OP_MUL: begin
                            acc_r <= acc_nxt_s;
                            lo_r  <= lo_nxt_s;
                            if (cnt_r == '0) begin
                                result <= {acc_nxt_s, lo_nxt_s};
                            end
                        end
                        OP_DIV: begin
                            if (div_zero_s) begin
                                err    <= 1'b1;
                                result <= '1;
                            end else begin
                                acc_r <= acc_nxt_s;
                                lo_r  <= lo_nxt_s;
                                if (cnt_r == '0) begin
                                    result <= {acc_nxt_s, lo_nxt_s};
                                end
                            end
                        end
                        default: begin
                            result <= result;
                        end
                    endcase
                    if (cnt_r == '0) begin
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed cases then randomized ops.
module tb_alu_seq_ctrl;

    localparam int N = 3;
    localparam int W = 2 * N;
    localparam int MOD = 1 << N;

    logic         clk_2 = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic         err;

    alu_seq_ctrl #(.NBITS(N)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 clk_2 = ~clk_2;

    int cyc = 0;
    always @(posedge clk_2) cyc <= cyc + 1;

    typedef struct {
        int    res;
        int    ovf;
        int    err;
        int    due;
        string name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour from plain arithmetic.
    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        e.ovf = 0;
        e.err = 0;
        e.due = 0;
        e.name = "";
        case (o)
            0: begin
                e.res = (x + y) % MOD;
                e.ovf = ((x + y) >= MOD) ? 1 : 0;
            end
            1: begin
                e.res = (x - y + MOD) % MOD;
                e.ovf = (x < y) ? 1 : 0;
            end
            2: e.res = x * y;
            default: begin
                if (y == 0) begin
                    e.res = (1 << W) - 1;
                    e.err = 1;
                end else begin
                    e.res = ((x % y) << N) | (x / y);
                end
            end
        endcase
        return e;
    endfunction

    function automatic int latency(input int o, input int y);
        if (o == 2) return N;
        if (o == 3 && y != 0) return N;
        return 1;
    endfunction

    // Monitor: pops the scoreboard whenever done is presented.
    bit   expect_busy_low = 1'b0;
    exp_t mon_e;
    always @(negedge clk_2) begin
        if (expect_busy_low) begin
            check("busy_after_done", int'(busy), 0);
            expect_busy_low = 1'b0;
        end
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, int'(result), mon_e.res);
                check({mon_e.name, "_ovf"}, int'(ovf), mon_e.ovf);
                check({mon_e.name, "_err"}, int'(err), mon_e.err);
                check({mon_e.name, "_busy_at_done"}, int'(busy), 1);
                check({mon_e.name, "_latency"}, cyc, mon_e.due);
                expect_busy_low = 1'b1;
            end
        end
    end

    task automatic run_op(input int o, input int x, input int y, input bit disturb, input string nm);
        exp_t e;
        int waited;
        waited = 0;
        @(negedge clk_2);
        while (busy && waited < 50) begin
            @(negedge clk_2);
            waited++;
        end
        if (busy) begin
            check({nm, "_idle_timeout"}, 1, 0);
            return;
        end
        start = 1'b1;
        op = 2'(o);
        a = N'(x);
        b = N'(y);
        e = model(o, x, y);
        e.name = nm;
        @(posedge clk_2);
        #1;
        e.due = cyc + latency(o, y);
        sb.push_back(e);
        @(negedge clk_2);
        if (disturb) begin
            start = 1'b1;
            op = 2'($urandom_range(0, 3));
            a = N'($urandom_range(0, MOD - 1));
            b = N'($urandom_range(0, MOD - 1));
        end else begin
            start = 1'b0;
        end
        @(negedge clk_2);
        start = 1'b0;
        a = N'($urandom_range(0, MOD - 1));
        b = N'($urandom_range(0, MOD - 1));
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clk_2);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_err", int'(err), 0);
        reset_n = 1'b1;

        run_op(0, 5, 6, 1'b0, "add_5_6");
        run_op(1, 2, 5, 1'b0, "sub_2_5");
        run_op(1, 5, 2, 1'b0, "sub_5_2");
        run_op(2, 7, 7, 1'b0, "mul_7_7");
        run_op(2, 0, 5, 1'b0, "mul_0_5");
        run_op(3, 7, 2, 1'b0, "div_7_2");
        run_op(3, 3, 0, 1'b0, "div_3_0");
        run_op(2, 7, 7, 1'b1, "mul_disturbed");
        run_op(0, 7, 1, 1'b1, "add_disturbed");

        // Asynchronous reset in the middle of a multiply.
        run_op(2, 6, 5, 1'b0, "mul_aborted");
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        sb.delete();
        @(negedge clk_2);
        @(negedge clk_2);
        reset_n = 1'b1;
        run_op(0, 1, 1, 1'b0, "add_after_reset");

        for (int i = 0; i < 80; i++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)),
                   int'($urandom_range(0, MOD - 1)), bit'($urandom_range(0, 1)), "rand");
        end

        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge clk_2);
            waited++;
        end
        @(negedge clk_2);
        check("drain_pending", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
